// File: rtl/hazard_pkg.sv
// Shared encodings and limits for the pipeline hazard unit.
// The forward-select codes are what the EX operand muxes decode.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;

    // Widest value ever loaded is LOAD_LAT+2 (no-forwarding load).
    function automatic int cnt_width(input int load_lat);
        return $clog2(load_lat + 3);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-result scoreboard: one down-counter per register,
// loaded when a writer issues and counting down to "value consumable".
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic [CW-1:0]     set_val,
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [REG_AW-1:0] rt_idx,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int NREG = 1 << REG_AW;

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            // A fresh writer overrides the countdown; register 0 never tracks.
            if (set_en && (i != 0) && (set_idx == REG_AW'(i))) begin
                cnt_d[i] = set_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rs_busy = (cnt_q[rs_idx] != '0);
    assign rt_busy = (cnt_q[rt_idx] != '0);

endmodule

// File: rtl/hazard_unit.sv
// Load-use / RAW hazard detection, EX operand forwarding select and a
// saturating stall counter. rst_n is an active-high synchronous reset.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic              memwb_reg_write,
    input  logic              flush,
    output logic              stall,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [15:0]       stall_cnt
);

    localparam int LAT = (LOAD_LAT < LOAD_LAT_MIN) ? LOAD_LAT_MIN :
                         (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
    localparam int CW  = cnt_width(LAT);
    // Without forwarding every result must reach the register file first.
    localparam int SET_LOAD = (FWD_EN != 0) ? LAT : LAT + 2;
    localparam int SET_ALU  = (FWD_EN != 0) ? 0 : 2;

    logic              rs_busy, rt_busy, issue;
    logic [CW-1:0]     set_val;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              exmem_fwd_ok, memwb_fwd_ok;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .CW     (CW)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue && id_reg_write),
        .set_idx (id_rd),
        .set_val (set_val),
        .rs_idx  (id_rs),
        .rt_idx  (id_rt),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy)
    );

    always_comb begin
        set_val     = id_mem_read ? CW'(SET_LOAD) : CW'(SET_ALU);
        stall       = id_valid && !flush &&
                      ((id_use_rs && (id_rs != '0) && rs_busy) ||
                       (id_use_rt && (id_rt != '0) && rt_busy));
        issue       = id_valid && !stall && !flush;
        idex_bubble = stall || flush;

        ex_rs_d = issue ? id_rs : '0;
        ex_rt_d = issue ? id_rt : '0;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // A load still in EX/MEM has no data yet, so it is never a forward source.
    always_comb begin
        exmem_fwd_ok = exmem_reg_write && !exmem_mem_read && (exmem_rd != '0);
        memwb_fwd_ok = memwb_reg_write && (memwb_rd != '0);
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0) begin
            if (exmem_fwd_ok && (exmem_rd == ex_rs_q)) begin
                fwd_a = FWD_EXMEM;
            end else if (memwb_fwd_ok && (memwb_rd == ex_rs_q)) begin
                fwd_a = FWD_MEMWB;
            end
            if (exmem_fwd_ok && (exmem_rd == ex_rt_q)) begin
                fwd_b = FWD_EXMEM;
            end else if (memwb_fwd_ok && (memwb_rd == ex_rt_q)) begin
                fwd_b = FWD_MEMWB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three configurations share one stimulus stream;
// each expected response names the instance it applies to.
module tb_hazard_unit;

    localparam int AW = 5;

    typedef struct packed {
        logic [7:0]  tag;
        logic [1:0]  sel;
        logic        stall;
        logic        bubble;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
    logic          id_use_rs, id_use_rt, id_valid, id_reg_write, id_mem_read;
    logic          exmem_reg_write, exmem_mem_read, memwb_reg_write, flush;

    logic        stall_o  [3];
    logic        bubble_o [3];
    logic [1:0]  fa_o     [3];
    logic [1:0]  fb_o     [3];
    logic [15:0] cnt_o    [3];

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int step   = 0;

    // Instance 0: LOAD_LAT=1 fwd on; 1: LOAD_LAT=3 fwd on; 2: LOAD_LAT=4 fwd off.
    hazard_unit #(.REG_AW(AW), .LOAD_LAT(1), .FWD_EN(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_valid(id_valid),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .memwb_reg_write(memwb_reg_write),
        .flush(flush), .stall(stall_o[0]), .idex_bubble(bubble_o[0]),
        .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .stall_cnt(cnt_o[0])
    );

    hazard_unit #(.REG_AW(AW), .LOAD_LAT(3), .FWD_EN(1)) u_l3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_valid(id_valid),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .memwb_reg_write(memwb_reg_write),
        .flush(flush), .stall(stall_o[1]), .idex_bubble(bubble_o[1]),
        .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .stall_cnt(cnt_o[1])
    );

    hazard_unit #(.REG_AW(AW), .LOAD_LAT(4), .FWD_EN(0)) u_nf (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_valid(id_valid),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .memwb_reg_write(memwb_reg_write),
        .flush(flush), .stall(stall_o[2]), .idex_bubble(bubble_o[2]),
        .fwd_a(fa_o[2]), .fwd_b(fb_o[2]), .stall_cnt(cnt_o[2])
    );

    // Monitor: drains every expectation issued this cycle, away from the edge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (stall_o[e.sel] !== e.stall || bubble_o[e.sel] !== e.bubble ||
                fa_o[e.sel] !== e.fa || fb_o[e.sel] !== e.fb || cnt_o[e.sel] !== e.cnt) begin
                errors++;
                $display("FAIL step %0d dut %0d: got stall=%b bubble=%b fwd_a=%b fwd_b=%b cnt=%h, expected stall=%b bubble=%b fwd_a=%b fwd_b=%b cnt=%h",
                         e.tag, e.sel, stall_o[e.sel], bubble_o[e.sel], fa_o[e.sel],
                         fb_o[e.sel], cnt_o[e.sel], e.stall, e.bubble, e.fa, e.fb, e.cnt);
            end
        end
    end

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input int v, input int rs, input int urs, input int rt,
                          input int urt, input int rd, input int rw, input int mr);
        id_valid     = (v != 0);
        id_rs        = AW'(rs);
        id_use_rs    = (urs != 0);
        id_rt        = AW'(rt);
        id_use_rt    = (urt != 0);
        id_rd        = AW'(rd);
        id_reg_write = (rw != 0);
        id_mem_read  = (mr != 0);
    endtask

    task automatic id_nop();
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pipe(input int erd, input int erw, input int emr, input int mrd, input int mrw);
        exmem_rd        = AW'(erd);
        exmem_reg_write = (erw != 0);
        exmem_mem_read  = (emr != 0);
        memwb_rd        = AW'(mrd);
        memwb_reg_write = (mrw != 0);
    endtask

    task automatic expect_out(input int sel, input int st, input int bub,
                              input int fa, input int fb, input int cnt);
        exp_t e;
        e.tag    = 8'(step);
        e.sel    = 2'(sel);
        e.stall  = (st != 0);
        e.bubble = (bub != 0);
        e.fa     = 2'(fa);
        e.fb     = 2'(fb);
        e.cnt    = 16'(cnt);
        step++;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        at_edge();
        rst_n = 1'b1;
        flush = 1'b0;
        id_nop();
        pipe(0, 0, 0, 0, 0);
        at_edge();
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        id_nop();
        pipe(0, 0, 0, 0, 0);

        // Reset state on every instance, with a real reader in ID.
        at_edge();
        id_set(1, 5, 1, 6, 1, 3, 1, 1);
        for (int s = 0; s < 3; s++) expect_out(s, 0, 0, 0, 0, 0);
        at_edge();
        rst_n = 1'b0;

        // lw r2 ; add r3,r2,r1 with LOAD_LAT=1
        do_reset();
        at_edge(); id_set(1, 1, 1, 0, 0, 2, 1, 1); expect_out(0, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 2, 1, 1, 1, 3, 1, 0); expect_out(0, 1, 1, 0, 0, 0);
        at_edge(); pipe(2, 1, 1, 0, 0);            expect_out(0, 0, 0, 0, 0, 1);
        at_edge(); id_nop(); pipe(0, 0, 0, 2, 1);  expect_out(0, 0, 0, 2, 0, 1);

        // ALU r4 then dependents: EX/MEM forward, MEM/WB forward, load excluded
        do_reset();
        at_edge(); id_set(1, 1, 1, 1, 1, 4, 1, 0); expect_out(0, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 4, 1, 6, 1, 5, 1, 0); expect_out(0, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 8, 1, 4, 1, 7, 1, 0); pipe(4, 1, 0, 4, 1);
        expect_out(0, 0, 0, 1, 0, 0);
        at_edge(); id_set(1, 4, 1, 4, 1, 9, 1, 0); pipe(5, 1, 0, 4, 1);
        expect_out(0, 0, 0, 0, 2, 0);
        at_edge(); id_nop(); pipe(4, 1, 1, 4, 1);  expect_out(0, 0, 0, 2, 2, 0);

        // lw r5 ; dependent with LOAD_LAT=3: three stalls, release on the fourth
        do_reset();
        at_edge(); id_set(1, 1, 1, 0, 0, 5, 1, 1); expect_out(1, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 5, 1, 0, 1, 6, 1, 0); expect_out(1, 1, 1, 0, 0, 0);
        at_edge(); expect_out(1, 1, 1, 0, 0, 1);
        at_edge(); expect_out(1, 1, 1, 0, 0, 2);
        at_edge(); expect_out(1, 0, 0, 0, 0, 3);
        at_edge(); id_nop(); pipe(0, 0, 0, 5, 1);  expect_out(1, 0, 0, 2, 0, 3);

        // No forwarding: ALU r6 -> two stalls; load r8 -> LOAD_LAT+2 = 6 stalls
        do_reset();
        at_edge(); id_set(1, 1, 1, 1, 1, 6, 1, 0); expect_out(2, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 6, 1, 6, 1, 7, 1, 0); pipe(1, 1, 0, 1, 1);
        expect_out(2, 1, 1, 0, 0, 0);
        at_edge(); pipe(6, 1, 0, 0, 0);            expect_out(2, 1, 1, 0, 0, 1);
        at_edge(); expect_out(2, 0, 0, 0, 0, 2);
        at_edge(); id_nop(); pipe(6, 1, 0, 6, 1);  expect_out(2, 0, 0, 0, 0, 2);
        at_edge(); id_set(1, 1, 1, 0, 0, 8, 1, 1); pipe(0, 0, 0, 0, 0);
        expect_out(2, 0, 0, 0, 0, 2);
        for (int i = 0; i < 6; i++) begin
            at_edge(); id_set(1, 8, 1, 0, 0, 9, 1, 0); expect_out(2, 1, 1, 0, 0, 2 + i);
        end
        at_edge(); expect_out(2, 0, 0, 0, 0, 8);

        // r0 never stalls; flush overrides a load-use stall and issues nothing
        do_reset();
        at_edge(); id_set(1, 1, 1, 0, 0, 0, 1, 1); expect_out(0, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 0, 1, 0, 1, 3, 1, 0); expect_out(0, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 1, 1, 0, 0, 2, 1, 1); expect_out(0, 0, 0, 0, 0, 0);
        at_edge(); id_set(1, 2, 1, 1, 1, 3, 1, 1); flush = 1'b1;
        expect_out(0, 0, 1, 0, 0, 0);
        at_edge(); flush = 1'b0; id_set(1, 3, 1, 0, 0, 4, 1, 0); pipe(1, 1, 0, 2, 1);
        expect_out(0, 0, 0, 0, 0, 0);

        // Saturation: self-dependent load r7 gives 6 stalls per 7 cycles
        do_reset();
        at_edge(); id_set(1, 7, 1, 0, 0, 7, 1, 1); pipe(0, 0, 0, 0, 0);
        repeat (76600) at_edge();
        id_nop(); expect_out(2, 0, 0, 0, 0, 16'hFFFF);
        at_edge(); id_set(1, 1, 1, 0, 0, 9, 1, 1);  expect_out(2, 0, 0, 0, 0, 16'hFFFF);
        at_edge(); id_set(1, 9, 1, 7, 1, 10, 1, 0); expect_out(2, 1, 1, 0, 0, 16'hFFFF);
        at_edge(); expect_out(2, 1, 1, 0, 0, 16'hFFFF);
        // Reset in the middle of the stall drops every pending hazard
        at_edge(); rst_n = 1'b1;
        at_edge(); rst_n = 1'b0; expect_out(2, 0, 0, 0, 0, 0);

        at_edge();
        at_edge();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5, meaning register-index width (2**REG_AW architectural registers; register 0 is hardwired zero).
REQ-002 Parameter LOAD_LAT, default 1, range 1..4, meaning cycles from load entering EX until its data is forwardable from MEM/WB.
REQ-003 Parameter FWD_EN, default 1, meaning 1 = forwarding enabled, 0 = no forwarding (stall until register-file write-back).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  reset; synchronous, active-high (asserted = 1); name kept for codebase consistency.
REQ-006 id_rs, id_rt  in  REG_AW each  ID-stage source indices.
REQ-007 id_use_rs, id_use_rt  in  1 each  ID instruction actually reads that source.
REQ-008 id_valid  in  1  ID holds a real instruction.
REQ-009 id_rd  in  REG_AW  destination of the ID instruction.
REQ-010 id_reg_write, id_mem_read  in  1 each  ID instruction writes a register / is a load.
REQ-011 exmem_rd, memwb_rd  in  REG_AW each  destinations in EX/MEM and MEM/WB.
REQ-012 exmem_reg_write, exmem_mem_read, memwb_reg_write  in  1 each  qualifiers for those destinations.
REQ-013 flush  in  1  taken branch/jump; kill the ID instruction this cycle.
REQ-014 stall  out  1  hold PC and IF/ID.
REQ-015 idex_bubble  out  1  insert NOP into ID/EX.
REQ-016 fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-017 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-018 Scoreboard: one down-counter per register, width ceil(log2(LOAD_LAT+3)), holding cycles until the pending value becomes consumable.
REQ-019 Issue occurs when id_valid && !stall && !flush; on issue with id_reg_write && id_rd != 0, set counter[id_rd] to the value in REQ-020.
REQ-020 Value set: FWD_EN=1: load -> LOAD_LAT, non-load -> 0; FWD_EN=0: load -> LOAD_LAT+2, non-load -> 2.
REQ-021 Every other nonzero counter decrements by 1 per cycle; set-on-issue wins over decrement for the same register.
REQ-022 stall is combinational: id_valid && !flush && ((id_use_rs && id_rs != 0 && counter[id_rs] != 0) || the same condition for rt).
REQ-023 idex_bubble = stall || flush.
REQ-024 No stall for register 0 under any condition.
REQ-025 fwd_a (FWD_EN=1): 01 if exmem_reg_write && !exmem_mem_read && exmem_rd != 0 && exmem_rd matches the EX rs; else 10 if memwb_reg_write && memwb_rd != 0 && match; else 00.
REQ-026 fwd_b follows the REQ-025 rule using rt; EX-stage rs/rt are registered copies of id_rs/id_rt captured on issue, zeroed on bubble.
REQ-027 FWD_EN=0: fwd_a = fwd_b = 00 always.
REQ-028 stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.
REQ-029 flush has priority over stall: no issue, no counter set, stall=0 that cycle.

Reset
REQ-030 rst_n=1 at a clock edge: all counters 0, EX-stage rs/rt 0, stall_cnt 0; combinationally stall=0, idex_bubble=0 (unless flush), fwd=00.
REQ-031 Reset asserted mid-stall discards all pending hazards; the next cycle after release issues without stall.

Structure
REQ-032 Shared package holds fwd-select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and LOAD_LAT bounds.
REQ-033 One sub-module, hazard_scoreboard (counter array, set/decrement/lookup); forwarding and stall logic stay in hazard_unit.

Verification
REQ-034 LOAD_LAT=1, FWD_EN=1: lw r2, then add r3,r2,r1 -> exactly 1 stall cycle, then fwd_a=10; stall_cnt=1.
REQ-035 LOAD_LAT=3: lw r5, then dependent on r5 -> 3 consecutive stall cycles, release on 4th, fwd=10.
REQ-036 ALU r4, then dependent on r4 (FWD_EN=1) -> no stall, fwd_a=01; second dependent two cycles later -> fwd=10.
REQ-037 FWD_EN=0: ALU r6, then dependent -> 2 stall cycles, fwd=00 throughout.
REQ-038 lw r0, then reader of r0 -> no stall; flush during a load-use stall -> stall=0, idex_bubble=1, no issue.
REQ-039 Force 70000 stall cycles -> stall_cnt=16'hFFFF; rst_n=1 -> stall_cnt=0 and counters cleared.
